sram_like_arbiter: RTL
======================

# sram_like_arbiter

Two-master to one-slave arbiter for the SRAM-like bus protocol (req/addr_ok/data_ok). It lets the IF-stage instruction port and the EX/MEM-stage data port share a single SRAM-like memory port. Responses return in order. A small ID FIFO records which master owns each outstanding transaction so that `data_ok`/`rdata` are routed back correctly. It sits between the pipeline's `inst_sram_*`/`data_sram_*` ports and the memory-side bridge.

## Interface
Parameters:
- `DEPTH`, 2: maximum outstanding (address-accepted, data-pending) transactions; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `inst_req`, `inst_wr`  in  1  instruction master request and write flag.
- `inst_size`  in  2  access size.
- `inst_wstrb`  in  4  byte strobes.
- `inst_addr`, `inst_wdata`  in  32  address and write data.
- `inst_addr_ok`, `inst_data_ok`  out  1  address handshake and data return.
- `inst_rdata`  out  32  read data.
- `data_*`  same set as `inst_*`, for the data master.
- `m_req`, `m_wr`  out  1  slave-side request and write flag.
- `m_size`  out  2  access size.
- `m_wstrb`  out  4  byte strobes.
- `m_addr`, `m_wdata`  out  32  address and write data.
- `m_addr_ok`, `m_data_ok`  in  1  slave handshakes.
- `m_rdata`  in  32  slave read data.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Grant selection, combinational:
  - If `lock` is set, grant = `lock_sel`.
  - Otherwise the data master wins if `data_req`; else the instruction master if `inst_req`.
- Slave port: `m_req = granted_req & ~full`. `m_wr`/`m_size`/`m_wstrb`/`m_addr`/`m_wdata` are muxed from the granted master, and hold the data master's values when nothing is granted.
- Address handshake: `inst_addr_ok = m_addr_ok & m_req & (grant==I)`. `data_addr_ok` is formed the same way for D. The non-granted master sees 0.
- Lock:
  - Set when `m_req & ~m_addr_ok`, with `lock_sel` = the current grant.
  - Cleared on `m_req & m_addr_ok`.
  - Masters must hold `req` and payload until `addr_ok`, so a presented request is never switched mid-handshake.
  - While `full`, `m_req=0`. `lock` is kept if already set. A pending master is not locked until it is actually presented.
- ID FIFO, 1 bit per entry (0=I, 1=D), with `rd_ptr`, `wr_ptr` and a `count` of width clog2(DEPTH)+1:
  - Push the grant ID on `m_req & m_addr_ok`.
  - Pop on `m_data_ok & ~empty`.
  - `full = (count==DEPTH)`, from registers only. A pop in the same cycle does not unblock issue.
  - Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Response routing: `inst_data_ok = m_data_ok & ~empty & (head==0)`, and `data_data_ok` is the same with `head==1`. `inst_rdata = data_rdata = m_rdata`.
- Errors: `m_data_ok` while empty is not forwarded, and sets `err`. `err` stays set until reset.
- Reset: `count`, pointers, `lock`, `lock_sel` and `err` go to 0. Pending transactions are discarded; the slave must be reset in the same cycle.

## Timing
- Request, grant and `addr_ok` are zero-latency combinational paths. `m_req` follows `*_req` in the same cycle.
- `data_ok` routing is zero-latency. Response ordering is strict FIFO across both masters.
- FIFO state, `lock` and `err` update on the clock edge after the handshake.
- Reset values (reset high, no requests): `m_req=0`; `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok`, `err` = 0; `m_*` payload = data-master inputs.
- With the slave always ready and no stall: one transaction accepted per cycle until `count==DEPTH`.
- After `full`: the first pop reopens issue in the next cycle.

## Structure
- Shared package `sram_like_pkg` holds:
  - localparams `ID_INST=1'b0`, `ID_DATA=1'b1`;
  - the field widths (addr 32, data 32, size 2, wstrb 4).
- One sub-module, `id_fifo`: DEPTH×1-bit synchronous FIFO with push/pop/full/empty/head and a synchronous active-high reset.
- The arbiter top holds the grant/lock logic and the muxes.

## Test plan
- **Single instruction read.** `inst_req` with addr 0x1C000000 and slave `addr_ok` in the same cycle; `m_data_ok` 2 cycles later with rdata 0x12345678. Required: `m_addr=0x1C000000`, `inst_addr_ok=1`, then `inst_data_ok=1`, `inst_rdata=0x12345678`, `data_data_ok=0`.
- **Simultaneous requests.** `inst_req` and a `data_req` write (addr 0x1C008000, wstrb 4'b0011) with slave always ready. Required: cycle 0 grants D (`m_wr=1`, `m_wstrb=0011`); cycle 1 grants I.
- **Lock.** `inst_req` alone with `m_addr_ok` low for 3 cycles; `data_req` rises in cycle 1. Required: `m_addr` stays the instruction address until `addr_ok`; D is granted in the following cycle.
- **Full.** DEPTH=2, two accepts with no `data_ok`, then a third request. Required: `m_req=0` and `count=2`. After one `m_data_ok`, the third request is issued in the next cycle.
- **Ordering and wrap-around.** Sequence I, D, I, D (wraps the pointers) with `data_ok` returned in order. Required: `data_ok` routed to I, D, I, D; `count` returns to 0.
- **Stray `data_ok` and mid-operation reset.** `m_data_ok` with the FIFO empty. Required: `err=1`, both `*_data_ok` stay 0. Then reset with one outstanding: `count=0`, `err=0`, `lock=0` on the next cycle.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared constants for the SRAM-like bus arbiter slice.
package sram_like_pkg;

  // Owner IDs recorded in the outstanding-transaction FIFO.
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  // Bus field widths.
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned WSTRB_W = 4;

endpackage

// File: rtl/id_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding the owner of each outstanding
// transaction. Flags are derived from registered state only.
module id_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = PW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (instruction/data) to one-slave arbiter for the SRAM-like bus.
// Data master has fixed priority; a presented but unaccepted request is locked
// until its address handshake. Responses are routed in order via id_fifo.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [SIZE_W-1:0]  inst_size,
  input  logic [WSTRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]  inst_addr,
  input  logic [DATA_W-1:0]  inst_wdata,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [DATA_W-1:0]  inst_rdata,

  input  logic               data_req,
  input  logic               data_wr,
  input  logic [SIZE_W-1:0]  data_size,
  input  logic [WSTRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [DATA_W-1:0]  data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [DATA_W-1:0]  data_rdata,

  output logic               m_req,
  output logic               m_wr,
  output logic [SIZE_W-1:0]  m_size,
  output logic [WSTRB_W-1:0] m_wstrb,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  input  logic               m_addr_ok,
  input  logic               m_data_ok,
  input  logic [DATA_W-1:0]  m_rdata,

  output logic               err
);

  logic lock_q, lock_d;
  logic lock_sel_q, lock_sel_d;
  logic err_q, err_d;

  logic grant_id;
  logic granted_req;
  logic sel_inst;
  logic full, empty, head;
  logic push, pop;

  // Grant selection: a locked master keeps the port, otherwise D beats I.
  // sel_inst is only true when I is actually granted, so an idle port
  // defaults the payload mux to the data master.
  always_comb begin
    if (lock_q) begin
      grant_id    = lock_sel_q;
      granted_req = (lock_sel_q == ID_DATA) ? data_req : inst_req;
    end else begin
      grant_id    = data_req ? ID_DATA : ID_INST;
      granted_req = data_req | inst_req;
    end
    sel_inst = granted_req & (grant_id == ID_INST);
  end

  assign m_req   = granted_req & ~full;
  assign m_wr    = sel_inst ? inst_wr    : data_wr;
  assign m_size  = sel_inst ? inst_size  : data_size;
  assign m_wstrb = sel_inst ? inst_wstrb : data_wstrb;
  assign m_addr  = sel_inst ? inst_addr  : data_addr;
  assign m_wdata = sel_inst ? inst_wdata : data_wdata;

  assign inst_addr_ok = m_addr_ok & m_req &  sel_inst;
  assign data_addr_ok = m_addr_ok & m_req & ~sel_inst;

  assign push = m_req & m_addr_ok;
  assign pop  = m_data_ok & ~empty;

  assign inst_data_ok = pop & (head == ID_INST);
  assign data_data_ok = pop & (head == ID_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err          = err_q;

  id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (grant_id),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Lock and sticky-error next state.
  always_comb begin
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    if (m_req && m_addr_ok) begin
      lock_d = 1'b0;
    end else if (m_req && !m_addr_ok) begin
      lock_d     = 1'b1;
      lock_sel_d = grant_id;
    end
    err_d = err_q | (m_data_ok & empty);
  end

  // Lock and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
    end
  end

endmodule
